// File: rtl/boot_loader_pkg.sv
// Shared definitions for the boot loader: FSM states, EEPROM command and frame geometry.
package boot_loader_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StRead,
        StGap,
        StDone
    } boot_state_e;

    localparam logic [7:0]  EepromCmdRead = 8'h03;
    localparam int unsigned BootFrameLen  = 24;
    localparam int unsigned WordBits      = 16;

    // Read command followed by a 16-bit start address of zero.
    function automatic logic [BootFrameLen-1:0] boot_frame();
        return {EepromCmdRead, 16'h0000};
    endfunction

endpackage

// File: rtl/boot_loader_shifter.sv
// 24-bit parallel-load shift register: serialises the command frame MSB first and
// assembles incoming EEPROM words in its low bits.
module boot_loader_shifter
    import boot_loader_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic                    shift,
    input  logic                    clear,
    input  logic                    shift_in,
    input  logic [BootFrameLen-1:0] frame,
    output logic                    msb,
    output logic [WordBits-1:0]     assembled
);

    logic [BootFrameLen-1:0] sh_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q <= '0;
        end else if (clear) begin
            sh_q <= '0;
        end else if (load) begin
            sh_q <= frame;
        end else if (shift) begin
            sh_q <= {sh_q[BootFrameLen-2:0], shift_in};
        end
    end

    assign msb       = sh_q[BootFrameLen-1];
    // Word as it will stand once the current input bit is shifted in.
    assign assembled = {sh_q[WordBits-2:0], shift_in};

endmodule

// File: rtl/boot_loader.sv
// Boot loader: streams the program image from the SPI EEPROM into SRAM after reset
// or a reboot request, then raises a sticky booted flag.
module boot_loader
    import boot_loader_pkg::*;
#(
    parameter int unsigned P_NUM_WORDS = 32768,
    parameter int unsigned P_CS_GAP    = 2
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        i_reboot,
    input  logic        i_storeSDO,
    output logic        o_storeEn,
    output logic        o_storeSDI,
    output logic [15:0] o_memAddr,
    output logic [15:0] o_memData,
    output logic        o_memWr,
    output logic        o_memEn,
    output logic        o_isBooted
);

    localparam int unsigned GapW     = $clog2(P_CS_GAP + 1);
    localparam logic [16:0] LastWord = 17'(P_NUM_WORDS - 1);
    localparam logic [4:0]  LastCmd  = 5'(BootFrameLen - 1);
    localparam logic [4:0]  LastBit  = 5'(WordBits - 1);
    localparam logic [GapW-1:0] LastGap = GapW'(P_CS_GAP - 1);

    boot_state_e         state_q;
    logic [4:0]          bit_cnt_q;
    logic [16:0]         word_cnt_q;
    logic [GapW-1:0]     gap_cnt_q;
    logic                store_en_q;
    logic                mem_we_q;
    logic [15:0]         mem_addr_q;
    logic [15:0]         mem_data_q;
    logic                booted_q;

    logic                abort;
    logic                sh_load;
    logic                sh_shift;
    logic                sh_in;
    logic                sh_msb;
    logic [WordBits-1:0] sh_word;

    always_comb begin
        abort    = i_reboot &&
                   (state_q == StCmd || state_q == StRead || state_q == StDone);
        sh_load  = (state_q == StIdle) || (state_q == StGap && gap_cnt_q == LastGap);
        sh_shift = (state_q == StCmd) || (state_q == StRead);
        // Zeros are shifted in during CMD so the frame drains cleanly into READ.
        sh_in    = i_storeSDO && (state_q == StRead);
    end

    boot_loader_shifter u_shifter (
        .clk       (i_clk),
        .rst_n     (i_rstn),
        .load      (sh_load),
        .shift     (sh_shift),
        .clear     (abort),
        .shift_in  (sh_in),
        .frame     (boot_frame()),
        .msb       (sh_msb),
        .assembled (sh_word)
    );

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q    <= StIdle;
            bit_cnt_q  <= '0;
            word_cnt_q <= '0;
            gap_cnt_q  <= '0;
            store_en_q <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            booted_q   <= 1'b0;
        end else begin
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            if (abort) begin
                state_q    <= StGap;
                gap_cnt_q  <= '0;
                bit_cnt_q  <= '0;
                word_cnt_q <= '0;
                store_en_q <= 1'b0;
                booted_q   <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        state_q    <= StCmd;
                        bit_cnt_q  <= '0;
                        store_en_q <= 1'b1;
                    end
                    StGap: begin
                        if (gap_cnt_q == LastGap) begin
                            state_q    <= StCmd;
                            bit_cnt_q  <= '0;
                            store_en_q <= 1'b1;
                        end else begin
                            gap_cnt_q <= gap_cnt_q + 1'b1;
                        end
                    end
                    StCmd: begin
                        if (bit_cnt_q == LastCmd) begin
                            state_q   <= StRead;
                            bit_cnt_q <= '0;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
                    StRead: begin
                        if (bit_cnt_q == LastBit) begin
                            bit_cnt_q  <= '0;
                            mem_we_q   <= 1'b1;
                            mem_addr_q <= word_cnt_q[15:0];
                            mem_data_q <= sh_word;
                            if (word_cnt_q == LastWord) begin
                                // Chip select drops together with the final write pulse.
                                state_q    <= StDone;
                                store_en_q <= 1'b0;
                            end else begin
                                word_cnt_q <= word_cnt_q + 1'b1;
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
                    StDone: begin
                        booted_q <= 1'b1;
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

    assign o_storeEn  = store_en_q;
    assign o_storeSDI = sh_msb && (state_q == StCmd);
    assign o_memEn    = mem_we_q;
    assign o_memWr    = mem_we_q;
    assign o_memAddr  = mem_addr_q;
    assign o_memData  = mem_data_q;
    assign o_isBooted = booted_q;

endmodule

// File: tb/tb_boot_loader.sv
// Randomised bench for boot_loader: a cycle-indexed model of the boot sequence drives
// the EEPROM data line and predicts every output each cycle.
module tb_boot_loader;

    localparam int unsigned NWords    = 4;
    localparam int unsigned CsGap     = 2;
    localparam int          LastPulse = 41 + 16 * (NWords - 1);

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        reboot = 1'b0;
    logic        sdo = 1'b0;
    logic        store_en;
    logic        store_sdi;
    logic [15:0] mem_addr;
    logic [15:0] mem_data;
    logic        mem_wr;
    logic        mem_en;
    logic        is_booted;

    // Cycle index within the current boot sequence; 1 is the first CMD cycle,
    // values <= 0 are idle/gap cycles.
    int          t;
    int          n_checks = 0;
    int          n_pass = 0;
    logic [15:0] eeprom [NWords];
    logic [23:0] frame = 24'h03_0000;

    boot_loader #(
        .P_NUM_WORDS (NWords),
        .P_CS_GAP    (CsGap)
    ) dut (
        .i_clk      (clk),
        .i_rstn     (rstn),
        .i_reboot   (reboot),
        .i_storeSDO (sdo),
        .o_storeEn  (store_en),
        .o_storeSDI (store_sdi),
        .o_memAddr  (mem_addr),
        .o_memData  (mem_data),
        .o_memWr    (mem_wr),
        .o_memEn    (mem_en),
        .o_isBooted (is_booted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s (t=%0d): got %0h, expected %0h", tag, t, got, exp);
    endtask

    task automatic check_cycle();
        logic        e_en, e_sdi, e_pulse, e_boot;
        logic [15:0] e_addr, e_data;
        e_en    = (t >= 1) && (t <= LastPulse - 1);
        e_sdi   = (t >= 1 && t <= 24) ? frame[24 - t] : 1'b0;
        e_pulse = (t >= 41) && (t <= LastPulse) && ((t - 41) % 16 == 0);
        e_addr  = e_pulse ? 16'((t - 41) / 16) : 16'h0;
        e_data  = e_pulse ? eeprom[(t - 41) / 16] : 16'h0;
        e_boot  = (t >= LastPulse + 1);
        check("store_en", 32'(store_en), 32'(e_en));
        check("store_sdi", 32'(store_sdi), 32'(e_sdi));
        check("mem_en", 32'(mem_en), 32'(e_pulse));
        check("mem_wr", 32'(mem_wr), 32'(e_pulse));
        check("mem_addr", 32'(mem_addr), 32'(e_addr));
        check("mem_data", 32'(mem_data), 32'(e_data));
        check("is_booted", 32'(is_booted), 32'(e_boot));
    endtask

    function automatic logic sdo_for(input int tc);
        int k, b;
        if (tc >= 25 && tc <= 24 + 16 * int'(NWords)) begin
            k = (tc - 25) / 16;
            b = 15 - (tc - 25) % 16;
            return eeprom[k][b];
        end
        return 1'($urandom_range(0, 1));
    endfunction

    // Called just after a rising edge: drive one cycle, check it, advance the model.
    task automatic step(input logic rb);
        reboot = rb;
        sdo    = sdo_for(t);
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
        if (rb && t >= 1) t = 1 - int'(CsGap);
        else t++;
        reboot = 1'b0;
    endtask

    task automatic run_until(input int target);
        int guard;
        guard = 0;
        while (t != target && guard < 1000) begin
            step(1'b0);
            guard++;
        end
        check("run_until_reached", 32'(t), 32'(target));
    endtask

    task automatic new_image();
        for (int i = 0; i < int'(NWords); i++) eeprom[i] = 16'($urandom);
        eeprom[0] = 16'hA5C3;
        if (NWords > 1) eeprom[1] = 16'h1234;
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        rstn = 1'b1;
        t    = 0;
    endtask

    initial begin
        new_image();
        t = 0;
        repeat (3) @(posedge clk);
        #1;
        check_cycle();
        release_reset();

        // Full boot from reset.
        run_until(LastPulse + 5);

        // Reboot while booted: full re-copy.
        step(1'b1);
        run_until(LastPulse + 5);

        // Reboot mid word 1.
        step(1'b1);
        run_until(45);
        step(1'b1);
        run_until(LastPulse + 5);

        // Asynchronous reset mid-copy.
        step(1'b1);
        run_until(50);
        rstn = 1'b0;
        #1;
        t = 0;
        check_cycle();
        @(negedge clk);
        check_cycle();
        new_image();
        release_reset();
        run_until(LastPulse + 5);

        // Random reboot pulses, including during idle and gap cycles.
        for (int i = 0; i < 1500; i++) begin
            step(1'($urandom_range(0, 59) == 0));
        end
        if (t < 1) run_until(1);
        run_until(t > LastPulse + 3 ? t + 2 : LastPulse + 4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
